// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
//   Iterative RV32M multiply/divide unit for the execute stage. One radix-2
//   step per cycle: a shift-add for the MUL family and a restoring subtract
//   for the DIV/REM family. Both work on operand magnitudes, and the sign is
//   fixed up on the last step. Division by zero and signed overflow are
//   resolved when the request is accepted and finish in a single cycle.
//
// Ports
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active-low
//   start    in   request, sampled only while idle
//   flush    in   synchronous abort (pipeline kill), has priority over start
//   funct3   in   RV32M operation select
//   rs1_val  in   operand a (register-file RD1)
//   rs2_val  in   operand b (register-file RD2)
//   rd_addr  in   destination register
//   busy     out  unit occupied (CALC or DONE)
//   done     out  one-cycle pulse, result valid
//   result   out  result, held until the next completed operation
//   wb_addr  out  latched rd_addr
//   wb_en    out  write-back enable (done and wb_addr != 0)
// ----------------------------------------------------------------------------
module muldiv_unit #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   rs1_val,
   input  logic [XLEN-1:0]   rs2_val,
   input  logic [REG_AW-1:0] rd_addr,
   output logic              busy,
   output logic              done,
   output logic [XLEN-1:0]   result,
   output logic [REG_AW-1:0] wb_addr,
   output logic              wb_en
);

   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_q, state_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                wb_en_q, wb_en_d;
   logic [XLEN-1:0]     result_q, result_d;
   logic [REG_AW-1:0]   wb_addr_q, wb_addr_d;
   logic [2:0]          f3_q, f3_d;
   logic [XLEN-1:0]     hi_q, hi_d;      // product upper half / partial remainder
   logic [XLEN-1:0]     lo_q, lo_d;      // multiplier bits / dividend-quotient bits
   logic [XLEN-1:0]     b_q, b_d;        // multiplicand / divisor magnitude
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                neg_q, neg_d;    // product / quotient negative
   logic                rneg_q, rneg_d;  // remainder negative

   // ---------------- request decode (used only in IDLE) ----------------
   logic            is_div, a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            b_zero, ovf, special;
   logic [XLEN-1:0] spec_res;

   always_comb begin
      is_div   = funct3[2];
      // MUL/MULH/MULHSU treat rs1 as signed; MUL/MULH treat rs2 as signed.
      // MUL's low word is sign-agnostic, so treating it as signed is harmless.
      a_signed = is_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
      b_signed = is_div ? ~funct3[0] : ~funct3[1];
      a_neg    = a_signed & rs1_val[XLEN-1];
      b_neg    = b_signed & rs2_val[XLEN-1];
      a_mag    = a_neg ? -rs1_val : rs1_val;
      b_mag    = b_neg ? -rs2_val : rs2_val;
      b_zero   = (rs2_val == '0);
      ovf      = is_div & ~funct3[0] &
                 (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) & (rs2_val == '1);
      special  = is_div & (b_zero | ovf);
      // funct3[1] separates REM* from DIV*
      if (b_zero) spec_res = funct3[1] ? rs1_val : '1;
      else        spec_res = funct3[1] ? '0 : rs1_val;
   end

   // ---------------- one iteration step ----------------
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift, div_diff;
   logic [XLEN-1:0]   hi_step, lo_step;

   always_comb begin
      // shift-add: add multiplicand into the upper half when the LSB is set,
      // then shift the whole 2*XLEN product right by one
      mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      // restoring division: shift the next dividend bit into the remainder
      div_shift = {hi_q, lo_q[XLEN-1]};
      div_diff  = div_shift - {1'b0, b_q};
      if (f3_q[2]) begin
         if (!div_diff[XLEN]) begin
            hi_step = div_diff[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], 1'b1};
         end else begin
            hi_step = div_shift[XLEN-1:0];
            lo_step = {lo_q[XLEN-2:0], 1'b0};
         end
      end else begin
         hi_step = mul_sum[XLEN:1];
         lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
      end
   end

   // ---------------- final sign fix and result select ----------------
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quot_s, rem_s, fin_res;

   always_comb begin
      prod_s = neg_q  ? -{hi_step, lo_step} : {hi_step, lo_step};
      quot_s = neg_q  ? -lo_step : lo_step;
      rem_s  = rneg_q ? -hi_step : hi_step;
      case (f3_q)
         3'b000:                 fin_res = prod_s[XLEN-1:0];
         3'b001, 3'b010, 3'b011: fin_res = prod_s[2*XLEN-1:XLEN];
         3'b100, 3'b101:         fin_res = quot_s;
         default:                fin_res = rem_s;
      endcase
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d   = state_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      wb_en_d   = 1'b0;
      result_d  = result_q;
      wb_addr_d = wb_addr_q;
      f3_d      = f3_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      b_d       = b_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      rneg_d    = rneg_q;
      case (state_q)
         IDLE: begin
            if (start && !flush) begin
               f3_d      = funct3;
               wb_addr_d = rd_addr;
               busy_d    = 1'b1;
               if (special) begin
                  state_d  = DONE;
                  result_d = spec_res;
                  done_d   = 1'b1;
                  wb_en_d  = (rd_addr != '0);
               end else begin
                  state_d = CALC;
                  cnt_d   = '0;
                  hi_d    = '0;
                  lo_d    = is_div ? a_mag : b_mag;
                  b_d     = is_div ? b_mag : a_mag;
                  neg_d   = a_neg ^ b_neg;
                  rneg_d  = a_neg;
               end
            end
         end
         CALC: begin
            if (flush) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               hi_d  = hi_step;
               lo_d  = lo_step;
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(XLEN-1)) begin
                  state_d  = DONE;
                  result_d = fin_res;
                  done_d   = 1'b1;
                  wb_en_d  = (wb_addr_q != '0);
               end
            end
         end
         default: begin
            // DONE: the pulse is already on the outputs; flush changes nothing here
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         wb_en_q   <= 1'b0;
         result_q  <= '0;
         wb_addr_q <= '0;
         f3_q      <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         b_q       <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         wb_en_q   <= wb_en_d;
         result_q  <= result_d;
         wb_addr_q <= wb_addr_d;
         f3_q      <= f3_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         b_q       <= b_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         rneg_q    <= rneg_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign wb_en   = wb_en_q;
   assign result  = result_q;
   assign wb_addr = wb_addr_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes the hand-computed
// response of every issued operation; the monitor pops on each done pulse.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, flush;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val;
   logic [4:0]  rd_addr;
   logic        busy, done, wb_en;
   logic [31:0] result;
   logic [4:0]  wb_addr;

   muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
      .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
      .busy(busy), .done(done), .result(result), .wb_addr(wb_addr), .wb_en(wb_en)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] res;
      logic [4:0]  addr;
      logic        en;
      int          lat;
      int          t0;
   } exp_t;
   exp_t sb[$];

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic [31:0] r;
      int          lat;
   } vec_t;
   vec_t vt[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: compare every done pulse against the oldest expectation
   always @(negedge clk) begin
      if (rst === 1'b1) begin
         check("wb_en_only_with_done", {31'b0, wb_en & ~done}, 32'h0);
         if (done === 1'b1) begin
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: result %h with no pending request", result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result",  result, e.res);
               check("wb_addr", {27'b0, wb_addr}, {27'b0, e.addr});
               check("wb_en",   {31'b0, wb_en},   {31'b0, e.en});
               check("latency", cyc - e.t0 + 1, e.lat);
            end
         end
      end
   end

   // called just after a negedge; returns at the negedge of cycle 1
   task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic [31:0] r, input int lat,
                        input bit expect_done);
      funct3 = f; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (expect_done) sb.push_back('{r, rd, (rd != 5'd0), lat, cyc});
      @(negedge clk);
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      if (busy) begin
         n_tests++; n_fail++;
         $display("FAIL wait_idle_timeout: busy still %b after %0d cycles", busy, n);
      end
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 100) begin @(negedge clk); n++; end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL wait_done_timeout: done still %b after %0d cycles", done, n);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      rst = 1'b0; start = 1'b0; flush = 1'b0;
      funct3 = 3'd0; rs1_val = '0; rs2_val = '0; rd_addr = '0;

      //          funct3  a             b             rd     expected      lat
      vt.push_back('{3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33});
      vt.push_back('{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 33});
      vt.push_back('{3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 33});
      vt.push_back('{3'b010, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 33});
      vt.push_back('{3'b001, 32'h80000000, 32'h80000000, 5'd9,  32'h40000000, 33});
      vt.push_back('{3'b011, 32'h80000000, 32'h00000002, 5'd10, 32'h00000001, 33});
      vt.push_back('{3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'h00000001, 33});
      vt.push_back('{3'b100, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, 1});
      vt.push_back('{3'b110, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h00000000, 1});
      vt.push_back('{3'b101, 32'h00000005, 32'h00000000, 5'd14, 32'hFFFFFFFF, 1});
      vt.push_back('{3'b111, 32'h00000005, 32'h00000000, 5'd15, 32'h00000005, 1});
      vt.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000000, 5'd16, 32'hFFFFFFFF, 1});
      vt.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000000, 5'd17, 32'hFFFFFFF9, 1});
      vt.push_back('{3'b100, 32'hFFFFFFF9, 32'h00000002, 5'd18, 32'hFFFFFFFD, 33});
      vt.push_back('{3'b110, 32'hFFFFFFF9, 32'h00000002, 5'd19, 32'hFFFFFFFF, 33});
      vt.push_back('{3'b101, 32'd100,      32'd7,        5'd20, 32'd14,       33});
      vt.push_back('{3'b111, 32'd100,      32'd7,        5'd21, 32'd2,        33});
      vt.push_back('{3'b100, 32'h00000007, 32'hFFFFFFFE, 5'd22, 32'hFFFFFFFD, 33});
      vt.push_back('{3'b110, 32'h00000007, 32'hFFFFFFFE, 5'd23, 32'h00000001, 33});
      vt.push_back('{3'b100, 32'h80000000, 32'h00000002, 5'd24, 32'hC0000000, 33});
      vt.push_back('{3'b101, 32'h80000000, 32'hFFFFFFFF, 5'd25, 32'h00000000, 33});
      vt.push_back('{3'b111, 32'h80000000, 32'hFFFFFFFF, 5'd26, 32'h80000000, 33});
      vt.push_back('{3'b000, 32'h00000003, 32'h00000004, 5'd0,  32'h0000000C, 33});

      // reset state
      repeat (3) @(negedge clk);
      check("rst_busy",    {31'b0, busy},  32'h0);
      check("rst_done",    {31'b0, done},  32'h0);
      check("rst_wb_en",   {31'b0, wb_en}, 32'h0);
      check("rst_result",  result,         32'h0);
      check("rst_wb_addr", {27'b0, wb_addr}, 32'h0);
      rst = 1'b1;
      @(negedge clk);

      // directed arithmetic vectors (last one has rd=0, so wb_en must stay low)
      foreach (vt[i]) begin
         issue(vt[i].f, vt[i].a, vt[i].b, vt[i].rd, vt[i].r, vt[i].lat, 1'b1);
         wait_idle();
         @(negedge clk);
      end

      // flush during cycle 10 of a DIV: no done, idle next cycle, result kept
      issue(3'b101, 32'd100, 32'd7, 5'd4, 32'd0, 0, 1'b0);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy",   {31'b0, busy}, 32'h0);
      check("flush_result", result,        32'h0000000C);
      repeat (40) @(negedge clk);
      check("flush_result_later", result, 32'h0000000C);

      // flush and start together while idle: nothing accepted
      funct3 = 3'b101; rs1_val = 32'd1; rs2_val = 32'd0; rd_addr = 5'd3;
      start = 1'b1; flush = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      check("flush_start_busy", {31'b0, busy}, 32'h0);
      @(negedge clk);

      // start while busy is ignored; back-to-back issue right after done
      issue(3'b000, 32'd6, 32'd7, 5'd9, 32'h0000002A, 33, 1'b1);
      @(negedge clk);
      funct3 = 3'b101; rs1_val = 32'd1; rs2_val = 32'd0; rd_addr = 5'd2;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      check("busy_during_calc", {31'b0, busy}, 32'h1);
      wait_done();
      @(negedge clk);
      check("idle_after_done", {31'b0, busy}, 32'h0);
      issue(3'b101, 32'd9, 32'd0, 5'd3, 32'hFFFFFFFF, 1, 1'b1);
      wait_idle();
      @(negedge clk);

      // asynchronous reset during cycle 20 of a MUL
      issue(3'b000, 32'h00000007, 32'hFFFFFFFD, 5'd5, 32'hFFFFFFEB, 33, 1'b1);
      repeat (19) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("arst_busy",    {31'b0, busy},  32'h0);
      check("arst_done",    {31'b0, done},  32'h0);
      check("arst_wb_en",   {31'b0, wb_en}, 32'h0);
      check("arst_result",  result,         32'h0);
      check("arst_wb_addr", {27'b0, wb_addr}, 32'h0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      repeat (40) @(negedge clk);

      // recovery after reset
      issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'hFFFFFFFE, 33, 1'b1);
      wait_idle();
      repeat (2) @(negedge clk);

      check("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
